aftab_sliced_llu: RTL and testbench
===================================

AFTAB_SLICED_LLU -- requirements
Module: aftab_sliced_llu

Interface
REQ-001 SHALL have parameter size, default 32, operand and result width in bits.
REQ-002 SHALL have parameter sliceWidth, default 8, bits processed per cycle; size SHALL be an integer multiple of sliceWidth (N = size/sliceWidth).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request to begin an operation.
REQ-006 SHALL have port a  input  size  first operand.
REQ-007 SHALL have port b  input  size  second operand.
REQ-008 SHALL have port selLogic  input  3  operation select.
REQ-009 SHALL have port busy  output  1  high while slices are being processed.
REQ-010 SHALL have port done  output  1  one-cycle pulse when lluResult becomes valid.
REQ-011 SHALL have port lluResult  output  size  registered result.

Function
REQ-012 selLogic encoding SHALL be: 000 a^b; 001 zero; 010 a|b; 011 a&b; 100 ~(a^b); 101 a&~b; 110 a|~b; 111 popcount(a), zero-extended to size.
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-014 In IDLE or DONE, start=1 at a rising edge SHALL latch a, b and selLogic, clear the slice counter and the accumulator, and enter BUSY.
REQ-015 In BUSY, each cycle SHALL process slice i (bits i*sliceWidth+sliceWidth-1 : i*sliceWidth) of the latched operands, then increment i.
REQ-016 Bitwise ops SHALL write the slice result into the matching bits of the result register; other bits SHALL stay unchanged.
REQ-017 For op 111, the ones-count of slice i of a SHALL be added to the accumulator; the accumulator width SHALL hold size without overflow.
REQ-018 After slice N-1 is processed, the FSM SHALL enter DONE, so that done is high exactly N cycles after the start edge.
REQ-019 In DONE, done=1 for exactly one cycle; without start the FSM SHALL return to IDLE on the next edge.
REQ-020 busy SHALL be 1 exactly in BUSY; done SHALL be 1 exactly in DONE.
REQ-021 lluResult SHALL change only at the DONE-entry edge and SHALL hold until the next DONE entry or reset; partial results SHALL never be visible.
REQ-022 start while BUSY SHALL be ignored, and the latched operands SHALL be unaffected.
REQ-023 start in DONE SHALL be accepted per REQ-014, giving back-to-back operations with no idle cycle.
REQ-024 Changes on a, b or selLogic after the start edge SHALL NOT affect the current result.
REQ-025 Op 001 SHALL still take N cycles and yield zero.
REQ-026 With N=1 (sliceWidth=size), done SHALL assert one cycle after start.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, busy=0, done=0, lluResult=0, slice counter=0 and accumulator=0, independent of clk.
REQ-028 Reset during BUSY SHALL abort the operation; no done SHALL follow it.
REQ-029 After rst deasserts, the first start SHALL behave per REQ-014.

Structure
REQ-030 The selLogic opcode constants and the FSM state encodings SHALL live in shared package aftab_llu_pkg.
REQ-031 Per-slice combinational logic (bitwise result and slice popcount) SHALL be sub-module aftab_llu_slice, parametrised by sliceWidth.
REQ-032 The slice counter width SHALL be clog2(N), with a minimum of 1.

Verification (size=32, sliceWidth=8, N=4)
REQ-033 Reset, then start with a=F0F0F0F0, b=FF00FF00, sel=000 -> done 4 cycles later, lluResult=0FF00FF0, busy high for 4 cycles.
REQ-034 sel=111, a=80000001 -> lluResult=00000002; a=FFFFFFFF -> 00000020.
REQ-035 Back-to-back: sel=011 then start in the DONE cycle with sel=101, a=FFFF0000, b=0F0F0F0F -> first result per op, then F0F00000 after 4 more cycles.
REQ-036 Assert start and change a during BUSY -> result reflects the originally latched a; exactly one done pulse.
REQ-037 Assert rst in the 2nd BUSY cycle -> outputs go to 0 asynchronously, no done follows, and the next operation is correct.
REQ-038 Sweep all 8 selLogic values with random operands -> lluResult matches the REQ-012 table.

Source files
------------

// File: rtl/aftab_llu_pkg.sv
// Shared definitions for the sliced logic unit: selLogic opcodes and FSM states.
//   opXor..opPopcount : 3-bit selLogic encodings
//   lluState_t        : controller state encoding (IDLE, BUSY, DONE)
package aftab_llu_pkg;

   localparam logic [2:0] opXor      = 3'b000;
   localparam logic [2:0] opZero     = 3'b001;
   localparam logic [2:0] opOr       = 3'b010;
   localparam logic [2:0] opAnd      = 3'b011;
   localparam logic [2:0] opXnor     = 3'b100;
   localparam logic [2:0] opAndNot   = 3'b101;
   localparam logic [2:0] opOrNot    = 3'b110;
   localparam logic [2:0] opPopcount = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } lluState_t;

endpackage

// File: rtl/aftab_llu_slice.sv
// Combinational logic for one operand slice.
//   aSlice, bSlice : slice of the latched operands
//   sel            : latched selLogic opcode
//   sliceResult    : bitwise result for this slice (zero for opZero/opPopcount)
//   sliceOnes      : number of set bits in aSlice
module aftab_llu_slice
   import aftab_llu_pkg::*;
#(
   parameter int unsigned sliceWidth = 8,
   parameter int unsigned onesWidth  = $clog2(sliceWidth + 1)
) (
   input  logic [sliceWidth-1:0] aSlice,
   input  logic [sliceWidth-1:0] bSlice,
   input  logic [2:0]            sel,
   output logic [sliceWidth-1:0] sliceResult,
   output logic [onesWidth-1:0]  sliceOnes
);

   // Bitwise operation on the slice
   always_comb begin
      sliceResult = '0;
      case (sel)
         opXor:    sliceResult = aSlice ^ bSlice;
         opZero:   sliceResult = '0;
         opOr:     sliceResult = aSlice | bSlice;
         opAnd:    sliceResult = aSlice & bSlice;
         opXnor:   sliceResult = ~(aSlice ^ bSlice);
         opAndNot: sliceResult = aSlice & ~bSlice;
         opOrNot:  sliceResult = aSlice | ~bSlice;
         default:  sliceResult = '0;
      endcase
   end

   // Ones count of the a slice
   always_comb begin
      sliceOnes = '0;
      for (int i = 0; i < int'(sliceWidth); i++) begin
         sliceOnes = sliceOnes + onesWidth'(aSlice[i]);
      end
   end

endmodule

// File: rtl/aftab_sliced_llu.sv
// Multi-cycle logic unit that processes size-bit operands sliceWidth bits per cycle.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin an operation (accepted in IDLE or DONE)
//   a, b       : operands, latched on the accepted start edge
//   selLogic   : operation select, latched with the operands
//   busy       : high while slices are being processed
//   done       : one-cycle pulse when lluResult is updated
//   lluResult  : registered result, updated only on entry to DONE
module aftab_sliced_llu
   import aftab_llu_pkg::*;
#(
   parameter int unsigned size       = 32,
   parameter int unsigned sliceWidth = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [size-1:0] a,
   input  logic [size-1:0] b,
   input  logic [2:0]      selLogic,
   output logic            busy,
   output logic            done,
   output logic [size-1:0] lluResult
);

   localparam int unsigned numSlices = size / sliceWidth;
   localparam int unsigned cntWidth  = (numSlices > 1) ? $clog2(numSlices) : 1;
   localparam int unsigned accWidth  = $clog2(size + 1);
   localparam int unsigned onesWidth = $clog2(sliceWidth + 1);
   localparam logic [cntWidth-1:0] lastSlice = cntWidth'(numSlices - 1);

   lluState_t state, stateNext;

   logic [numSlices-1:0][sliceWidth-1:0] aReg, bReg, workReg, workMerged;
   logic [2:0]           selReg;
   logic [cntWidth-1:0]  sliceCnt;
   logic [accWidth-1:0]  accum, accumNext;
   logic [sliceWidth-1:0] sliceResult;
   logic [onesWidth-1:0]  sliceOnes;
   logic                  accept, lastStep;

   assign accept   = start && (state != BUSY);
   assign lastStep = (state == BUSY) && (sliceCnt == lastSlice);

   aftab_llu_slice #(
      .sliceWidth (sliceWidth),
      .onesWidth  (onesWidth)
   ) sliceUnit (
      .aSlice      (aReg[sliceCnt]),
      .bSlice      (bReg[sliceCnt]),
      .sel         (selReg),
      .sliceResult (sliceResult),
      .sliceOnes   (sliceOnes)
   );

   // Partial result with the current slice folded in; feeds lluResult on the last step
   always_comb begin
      workMerged           = workReg;
      workMerged[sliceCnt] = sliceResult;
      accumNext            = accum + accWidth'(sliceOnes);
   end

   // State register; busy/done are registered copies of the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= stateNext;
         busy  <= (stateNext == BUSY);
         done  <= (stateNext == DONE);
      end
   end

   // Next-state logic
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start) stateNext = BUSY;
         BUSY:    if (sliceCnt == lastSlice) stateNext = DONE;
         DONE:    stateNext = start ? BUSY : IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Operand latch, slice walk and result update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aReg      <= '0;
         bReg      <= '0;
         selReg    <= '0;
         sliceCnt  <= '0;
         accum     <= '0;
         workReg   <= '0;
         lluResult <= '0;
      end else if (accept) begin
         aReg     <= a;
         bReg     <= b;
         selReg   <= selLogic;
         sliceCnt <= '0;
         accum    <= '0;
         workReg  <= '0;
      end else if (state == BUSY) begin
         workReg  <= workMerged;
         accum    <= accumNext;
         sliceCnt <= sliceCnt + cntWidth'(1);
         if (lastStep) begin
            lluResult <= (selReg == opPopcount) ? size'(accumNext) : size'(workMerged);
         end
      end
   end

endmodule

// File: tb/tb_aftab_sliced_llu.sv
// Directed self-checking bench for aftab_sliced_llu (size=32, sliceWidth=8).
module tb_aftab_sliced_llu;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] a, b;
   logic [2:0]  selLogic;
   logic        busy, done;
   logic [31:0] lluResult;

   int passCount  = 0;
   int checkCount = 0;

   aftab_sliced_llu #(.size(32), .sliceWidth(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .selLogic  (selLogic),
      .busy      (busy),
      .done      (done),
      .lluResult (lluResult)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic [2:0] s);
      case (s)
         3'd0:    return x ^ y;
         3'd1:    return 32'h0;
         3'd2:    return x | y;
         3'd3:    return x & y;
         3'd4:    return ~(x ^ y);
         3'd5:    return x & ~y;
         3'd6:    return x | ~y;
         default: return 32'($countones(x));
      endcase
   endfunction

   // Issue one operation from IDLE and wait (bounded) for done.
   // lat counts cycles from the start edge to the done edge; -1 on timeout.
   task automatic doOp(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] is,
                       output logic [31:0] res, output int lat, output int busyCnt);
      @(negedge clk);
      a = ia; b = ib; selLogic = is; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0; busyCnt = 0;
      while (!done && lat < 20) begin
         if (busy) busyCnt++;
         @(negedge clk);
         lat++;
      end
      if (!done) lat = -1;
      res = lluResult;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0; selLogic = '0;
      @(negedge clk);
      checkCount++;
      if (busy !== 1'b0 || done !== 1'b0 || lluResult !== 32'h0)
         $display("FAIL reset_outputs busy=%b done=%b result=%h required 0 0 00000000", busy, done, lluResult);
      else passCount++;
      start = 1'b1;
      @(negedge clk);
      checkCount++;
      if (busy !== 1'b0)
         $display("FAIL reset_holds_idle busy=%b required 0", busy);
      else passCount++;
      start = 1'b0; rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_xor();
      logic [31:0] res; int lat, bc;
      doOp(32'hF0F0F0F0, 32'hFF00FF00, 3'b000, res, lat, bc);
      checkCount++;
      if (res !== 32'h0FF00FF0) $display("FAIL xor_result got=%h required=0ff00ff0", res);
      else passCount++;
      checkCount++;
      if (lat !== 4) $display("FAIL xor_latency got=%0d required=4", lat);
      else passCount++;
      checkCount++;
      if (bc !== 4) $display("FAIL xor_busy_cycles got=%0d required=4", bc);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if (done !== 1'b0 || busy !== 1'b0 || lluResult !== 32'h0FF00FF0)
         $display("FAIL xor_return_idle done=%b busy=%b result=%h required 0 0 0ff00ff0", done, busy, lluResult);
      else passCount++;
   endtask

   task automatic test_popcount();
      logic [31:0] res; int lat, bc;
      doOp(32'h80000001, 32'h12345678, 3'b111, res, lat, bc);
      checkCount++;
      if (res !== 32'h00000002 || lat !== 4) $display("FAIL popcount_two got=%h lat=%0d required=00000002 lat=4", res, lat);
      else passCount++;
      doOp(32'hFFFFFFFF, 32'h0, 3'b111, res, lat, bc);
      checkCount++;
      if (res !== 32'h00000020) $display("FAIL popcount_all got=%h required=00000020", res);
      else passCount++;
      doOp(32'hDEADBEEF, 32'hFFFFFFFF, 3'b001, res, lat, bc);
      checkCount++;
      if (res !== 32'h0 || lat !== 4) $display("FAIL zero_op got=%h lat=%0d required=00000000 lat=4", res, lat);
      else passCount++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] res; int lat, bc; int cyc;
      doOp(32'h12345678, 32'h0F0F0F0F, 3'b011, res, lat, bc);
      checkCount++;
      if (res !== 32'h02040608) $display("FAIL b2b_first got=%h required=02040608", res);
      else passCount++;
      // Still in the DONE cycle: issue the next operation immediately
      a = 32'hFFFF0000; b = 32'h0F0F0F0F; selLogic = 3'b101; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkCount++;
      if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_no_idle busy=%b done=%b required 1 0", busy, done);
      else passCount++;
      cyc = 0;
      while (!done && cyc < 20) begin
         checkCount++;
         if (lluResult !== 32'h02040608) $display("FAIL b2b_hold got=%h required=02040608", lluResult);
         else passCount++;
         @(negedge clk);
         cyc++;
      end
      checkCount++;
      if (!done || cyc !== 4 || lluResult !== 32'hF0F00000)
         $display("FAIL b2b_second done=%b cycles=%0d got=%h required 1 4 f0f00000", done, cyc, lluResult);
      else passCount++;
   endtask

   task automatic test_start_during_busy();
      int doneCnt; logic [31:0] res;
      @(negedge clk);
      a = 32'h0000FFFF; b = 32'h00FF00FF; selLogic = 3'b000; start = 1'b1;
      @(negedge clk);
      a = 32'hFFFFFFFF; b = 32'h0; selLogic = 3'b111;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      doneCnt = 0; res = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) begin doneCnt++; res = lluResult; end
      end
      checkCount++;
      if (res !== 32'h00FFFF00) $display("FAIL busy_start_result got=%h required=00ffff00", res);
      else passCount++;
      checkCount++;
      if (doneCnt !== 1) $display("FAIL busy_start_done_count got=%0d required=1", doneCnt);
      else passCount++;
   endtask

   task automatic test_reset_during_busy();
      int doneCnt; logic [31:0] res; int lat, bc;
      @(negedge clk);
      a = 32'hAAAA5555; b = 32'h0; selLogic = 3'b010; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkCount++;
      if (busy !== 1'b0 || done !== 1'b0 || lluResult !== 32'h0)
         $display("FAIL async_reset busy=%b done=%b result=%h required 0 0 00000000", busy, done, lluResult);
      else passCount++;
      @(negedge clk);
      rst = 1'b0;
      doneCnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) doneCnt++;
      end
      checkCount++;
      if (doneCnt !== 0) $display("FAIL reset_abort_done got=%0d required=0", doneCnt);
      else passCount++;
      doOp(32'h0F0F0F0F, 32'h00FF00FF, 3'b110, res, lat, bc);
      checkCount++;
      if (res !== 32'hFF0FFF0F || lat !== 4) $display("FAIL after_reset_op got=%h lat=%0d required=ff0fff0f lat=4", res, lat);
      else passCount++;
   endtask

   task automatic test_sweep();
      logic [31:0] res, ra, rb, exp; int lat, bc;
      for (int s = 0; s < 8; s++) begin
         ra = $urandom; rb = $urandom;
         exp = model(ra, rb, 3'(s));
         doOp(ra, rb, 3'(s), res, lat, bc);
         checkCount++;
         if (res !== exp || lat !== 4)
            $display("FAIL sweep_sel%0d a=%h b=%h got=%h lat=%0d required=%h lat=4", s, ra, rb, res, lat, exp);
         else passCount++;
      end
   endtask

   initial begin
      test_reset();
      test_xor();
      test_popcount();
      test_back_to_back();
      test_start_during_busy();
      test_reset_during_busy();
      test_sweep();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
